// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state type,
// register offsets (ADD_I[3:2]) and STATUS bit positions.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_EDGE    = 2'd3;

  localparam int STAT_GIE    = 0;
  localparam int STAT_ID_LSB = 1;
  localparam int STAT_ID_MSB = 3;
  localparam int STAT_INSVC  = 4;
  localparam int STAT_EOI    = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: o_valid when any bit is set,
// o_idx is the position of the lowest set bit.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] i_vec,
  output logic         o_valid,
  output logic [2:0]   o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: MASK/PENDING/STATUS/EDGE registers, edge or level
// capture per line, fixed lowest-index priority, IDLE/REQ/SERVICE FSM.
// Optional macro IRQ_CTRL_SYNC_EN inserts a two-flop synchronizer on
// HWINT_I ahead of the capture logic (two extra cycles of latency).
//
// CPU handshake: INT_REQ_O is high exactly while the FSM is in REQ, with
// INT_ID_O stable; INT_ACK_I is sampled only in that state (a pulse at
// any other time is ignored). The ack moves the FSM to SERVICE, which is
// left only by an EOI write (STATUS bit31 = 1).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 6
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [3:2]         ADD_I,
  input  logic               WE_I,
  input  logic [31:0]        DAT_I,
  output logic [31:0]        DAT_O,
  input  logic [NUM_IRQ-1:0] HWINT_I,
  output logic               INT_REQ_O,
  input  logic               INT_ACK_I,
  output logic [2:0]         INT_ID_O,
  output logic [1:0]         o_dbg_state
);

  logic [NUM_IRQ-1:0] w_hw;
  logic [NUM_IRQ-1:0] r_hw_d;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_edge;
  logic [NUM_IRQ-1:0] r_pend_e;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_enabled;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic               r_gie;
  logic [2:0]         r_active_id;
  logic               r_req_vld;
  logic [2:0]         r_req_id;
  logic               w_enc_valid;
  logic [2:0]         w_enc_idx;
  logic               w_cand_ok;
  logic               w_act_ok;
  logic               w_act_edge;
  logic               w_load;
  logic               w_ack_clr;
  irq_state_t         r_state;
  irq_state_t         w_state_nxt;

  logic w_wr_mask, w_wr_pend, w_wr_status, w_wr_edge, w_eoi;
  logic w_unused_dat;

  assign w_wr_mask    = WE_I && (ADD_I == REG_MASK);
  assign w_wr_pend    = WE_I && (ADD_I == REG_PENDING);
  assign w_wr_status  = WE_I && (ADD_I == REG_STATUS);
  assign w_wr_edge    = WE_I && (ADD_I == REG_EDGE);
  assign w_eoi        = w_wr_status && DAT_I[STAT_EOI];
  assign w_unused_dat = ^DAT_I[30:NUM_IRQ];

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  // Two-flop synchronizer for asynchronous device lines.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= HWINT_I;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hw = r_sync2;
`else
  assign w_hw = HWINT_I;
`endif

  // Input history: previous sample for edge detect, and the level value.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_hw_d <= '0;
    else       r_hw_d <= w_hw;
  end

  // Level lines show the registered input; edge lines show the sticky bit.
  assign w_pending = (r_edge & r_pend_e) | (~r_edge & r_hw_d);
  assign w_enabled = w_pending & r_mask;
  assign w_set     = w_hw & ~r_hw_d & r_edge;

  // Clear sources for sticky bits: W1C write and ack of an edge line.
  always_comb begin
    w_clr = w_wr_pend ? DAT_I[NUM_IRQ-1:0] : '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_ack_clr && (r_active_id == 3'(i))) w_clr[i] = 1'b1;
    end
  end

  // Sticky edge pending bits; a new edge wins over a clear in the same cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_pend_e <= '0;
    else       r_pend_e <= (w_set | (r_pend_e & ~w_clr)) & r_edge;
  end

  // Software-writable configuration registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_mask <= '0;
      r_edge <= '0;
      r_gie  <= 1'b0;
    end else begin
      if (w_wr_mask)   r_mask <= DAT_I[NUM_IRQ-1:0];
      if (w_wr_edge)   r_edge <= DAT_I[NUM_IRQ-1:0];
      if (w_wr_status) r_gie  <= DAT_I[STAT_GIE];
    end
  end

  irq_prio_enc #(.N(NUM_IRQ)) u_enc (
    .i_vec   (w_enabled),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  // Registered winner of the priority encoder; IDLE latches from this.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_req_vld <= 1'b0;
      r_req_id  <= 3'd0;
    end else begin
      r_req_vld <= r_gie & w_enc_valid;
      r_req_id  <= w_enc_idx;
    end
  end

  // Is the candidate / active line still pending, enabled and GIE set?
  always_comb begin
    w_cand_ok  = 1'b0;
    w_act_ok   = 1'b0;
    w_act_edge = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (r_req_id == 3'(i)) w_cand_ok = w_enabled[i];
      if (r_active_id == 3'(i)) begin
        w_act_ok   = w_enabled[i];
        w_act_edge = r_edge[i];
      end
    end
    w_cand_ok = w_cand_ok & r_req_vld & r_gie;
    w_act_ok  = w_act_ok & r_gie;
  end

  // FSM state register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and request outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack_clr   = 1'b0;
    INT_REQ_O   = 1'b0;
    INT_ID_O    = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_cand_ok) begin
          w_state_nxt = ST_REQ;
          w_load      = 1'b1;
        end
      end
      ST_REQ: begin
        INT_REQ_O = 1'b1;
        INT_ID_O  = r_active_id;
        if (!w_act_ok) begin
          w_state_nxt = ST_IDLE;
        end else if (INT_ACK_I) begin
          w_state_nxt = ST_SERVICE;
          w_ack_clr   = w_act_edge;
        end
      end
      ST_SERVICE: begin
        if (w_eoi) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Active ID is captured on the IDLE->REQ transition and held after.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)       r_active_id <= 3'd0;
    else if (w_load) r_active_id <= r_req_id;
  end

  // Combinational register read mux.
  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      REG_MASK:    DAT_O = 32'(r_mask);
      REG_PENDING: DAT_O = 32'(w_pending);
      REG_STATUS: begin
        DAT_O[STAT_GIE]                 = r_gie;
        DAT_O[STAT_ID_MSB:STAT_ID_LSB]  = r_active_id;
        DAT_O[STAT_INSVC]               = (r_state == ST_SERVICE);
      end
      default:     DAT_O = 32'(r_edge);
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// traffic, all checked each cycle against a behavioural model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 6;
  localparam logic [7:0] LMASK = 8'((1 << N) - 1);

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic [3:2]    ADD_I;
  logic          WE_I;
  logic [31:0]   DAT_I;
  logic [31:0]   DAT_O;
  logic [N-1:0]  HWINT_I;
  logic          INT_REQ_O;
  logic          INT_ACK_I;
  logic [2:0]    INT_ID_O;
  logic [1:0]    o_dbg_state;

  irq_ctrl #(.NUM_IRQ(N)) dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .ADD_I       (ADD_I),
    .WE_I        (WE_I),
    .DAT_I       (DAT_I),
    .DAT_O       (DAT_O),
    .HWINT_I     (HWINT_I),
    .INT_REQ_O   (INT_REQ_O),
    .INT_ACK_I   (INT_ACK_I),
    .INT_ID_O    (INT_ID_O),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK_I = ~CLK_I;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: registers as bytes, sticky edge flags, last sampled
  // inputs, the FSM phase (0 idle, 1 requesting, 2 in service) and the
  // lowest pending+enabled line seen one cycle earlier.
  logic [7:0] m_mask, m_edge, m_sticky, m_prev, m_s1, m_s2;
  logic       m_gie;
  int         m_phase, m_active;
  logic       m_cand_vld;
  int         m_cand_id;
  logic [5:0] exp_q[$];

  function automatic logic [7:0] m_pending();
    return ((m_edge & m_sticky) | (~m_edge & m_prev)) & LMASK;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_pending());
      2'd2:    return {27'd0, (m_phase == 2), 3'(m_active), m_gie};
      default: return 32'(m_edge);
    endcase
  endfunction

  task automatic model_reset();
    m_mask = 0; m_edge = 0; m_sticky = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
    m_gie = 0; m_phase = 0; m_active = 0; m_cand_vld = 0; m_cand_id = 0;
  endtask

  task automatic model_step();
    logic [7:0] hw, enabled, setb, clrb;
    logic       ackclr, nv;
    int         nid;
`ifdef IRQ_CTRL_SYNC_EN
    hw   = m_s2;
    m_s2 = m_s1;
    m_s1 = 8'(HWINT_I);
`else
    hw = 8'(HWINT_I);
`endif
    enabled = m_pending() & m_mask;
    ackclr  = 1'b0;
    case (m_phase)
      0: if (m_cand_vld && m_gie && enabled[m_cand_id]) begin
           m_phase  = 1;
           m_active = m_cand_id;
         end
      1: if (!(m_gie && enabled[m_active])) m_phase = 0;
         else if (INT_ACK_I) begin
           m_phase = 2;
           ackclr  = m_edge[m_active];
         end
      default: if (WE_I && ADD_I == REG_STATUS && DAT_I[31]) m_phase = 0;
    endcase
    // lowest enabled line, for the next latch opportunity
    nv = m_gie && (enabled != 0);
    nid = 0;
    for (int i = 7; i >= 0; i--) if (enabled[i]) nid = i;
    m_cand_vld = nv;
    m_cand_id  = nid;
    // sticky edge flags: new edge beats any clear
    setb = hw & ~m_prev & m_edge;
    clrb = (WE_I && ADD_I == REG_PENDING) ? DAT_I[7:0] : 8'd0;
    if (ackclr) clrb[m_active] = 1'b1;
    m_sticky = (setb | (m_sticky & ~clrb)) & m_edge & LMASK;
    if (WE_I) begin
      case (ADD_I)
        REG_MASK:   m_mask = DAT_I[7:0] & LMASK;
        REG_STATUS: m_gie  = DAT_I[0];
        REG_EDGE:   m_edge = DAT_I[7:0] & LMASK;
        default: ;
      endcase
    end
    m_prev = hw & LMASK;
    exp_q.push_back({2'(m_phase), (m_phase == 1), (m_phase == 1) ? 3'(m_active) : 3'd0});
  endtask

  // ---------------- drivers ----------------
  // One clock: advance model on the edge, compare outputs on the falling edge.
  task automatic tick();
    logic [5:0] e;
    @(posedge CLK_I);
    if (RST_I) begin
      model_reset();
      exp_q.push_back(6'd0);
    end else begin
      model_step();
    end
    @(negedge CLK_I);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("state", 32'(o_dbg_state), 32'(e[5:4]));
      check("int_req", 32'(INT_REQ_O), 32'(e[3]));
      check("int_id", 32'(INT_ID_O), 32'(e[2:0]));
      check("dat_o", DAT_O, m_read(ADD_I));
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    ADD_I = a; WE_I = 1'b1; DAT_I = d;
    tick();
    WE_I = 1'b0; DAT_I = 32'd0;
  endtask

  task automatic ack_pulse();
    INT_ACK_I = 1'b1;
    tick();
    INT_ACK_I = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ADD_I = a;
    #1;
    check(tag, DAT_O, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_I = 1'b1; ADD_I = 2'd0; WE_I = 1'b0; DAT_I = 32'd0;
    HWINT_I = '0; INT_ACK_I = 1'b0;
    model_reset();
    tick(); tick();
    RST_I = 1'b0;
    tick();

    // reset state
    check("rst_int_req", 32'(INT_REQ_O), 32'd0);
    check("rst_int_id", 32'(INT_ID_O), 32'd0);
    for (int a = 0; a < 4; a++) read_check("rst_reg", 2'(a), 32'd0);

    // single edge on timer line: pending after 1 cycle, request 2 later
    bus_write(REG_STATUS, 32'h1);
    bus_write(REG_MASK, 32'h01);
    bus_write(REG_EDGE, 32'h01);
    HWINT_I[0] = 1'b1;
    tick();
    HWINT_I[0] = 1'b0;
    read_check("t1_pending", REG_PENDING, 32'h01);
    check("t1_req_early", 32'(INT_REQ_O), 32'd0);
    tick();
    check("t1_req_early2", 32'(INT_REQ_O), 32'd0);
    tick();
    check("t1_req", 32'(INT_REQ_O), 32'd1);
    check("t1_id", 32'(INT_ID_O), 32'd0);
    ack_pulse();
    read_check("t1_status_svc", REG_STATUS, 32'h11);
    read_check("t1_pend_clr", REG_PENDING, 32'h00);
    bus_write(REG_STATUS, 32'h8000_0001);
    check("t1_eoi_idle", 32'(o_dbg_state), 32'(ST_IDLE));

    // simultaneous edges on lines 3 and 1: lowest first
    bus_write(REG_MASK, 32'h3F);
    bus_write(REG_EDGE, 32'h3F);
    HWINT_I = 6'b001010;
    tick();
    HWINT_I = '0;
    tick(); tick();
    check("t2_id_first", 32'(INT_ID_O), 32'd1);
    ack_pulse();
    bus_write(REG_STATUS, 32'h8000_0001);
    tick();
    check("t2_req_second", 32'(INT_REQ_O), 32'd1);
    check("t2_id_second", 32'(INT_ID_O), 32'd3);
    ack_pulse();
    bus_write(REG_STATUS, 32'h8000_0001);
    tick();

    // masking the line while requesting withdraws the request
    HWINT_I[2] = 1'b1;
    tick();
    HWINT_I[2] = 1'b0;
    tick(); tick();
    check("t3_id", 32'(INT_ID_O), 32'd2);
    bus_write(REG_MASK, 32'h00);
    tick();
    check("t3_req_drop", 32'(INT_REQ_O), 32'd0);
    check("t3_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    read_check("t3_pend_kept", REG_PENDING, 32'h04);
    bus_write(REG_PENDING, 32'h04);

    // edge and W1C of the same bit in one cycle: set wins
    HWINT_I[0] = 1'b1;
    bus_write(REG_PENDING, 32'h01);
    read_check("t4_set_wins", REG_PENDING, 32'h01);
    HWINT_I[0] = 1'b0;
    bus_write(REG_PENDING, 32'h01);
    read_check("t4_w1c", REG_PENDING, 32'h00);

    // level line 4 held: re-request after EOI, release clears it
    bus_write(REG_EDGE, 32'h2F);
    bus_write(REG_MASK, 32'h10);
    HWINT_I[4] = 1'b1;
    tick(); tick(); tick();
    check("t5_id", 32'(INT_ID_O), 32'd4);
    ack_pulse();
    read_check("t5_level_pend", REG_PENDING, 32'h10);
    bus_write(REG_STATUS, 32'h8000_0001);
    tick();
    check("t5_rereq", 32'(INT_REQ_O), 32'd1);
    check("t5_reid", 32'(INT_ID_O), 32'd4);
    ack_pulse();
    HWINT_I[4] = 1'b0;
    bus_write(REG_STATUS, 32'h8000_0001);
    tick(); tick(); tick();
    read_check("t5_released", REG_PENDING, 32'h00);
    check("t5_no_req", 32'(INT_REQ_O), 32'd0);

    // reset while requesting drops the request at once
    HWINT_I[4] = 1'b1;
    tick(); tick(); tick();
    check("t6_req", 32'(INT_REQ_O), 32'd1);
    RST_I = 1'b1;
    #1;
    check("t6_rst_drop", 32'(INT_REQ_O), 32'd0);
    HWINT_I = '0;
    tick(); tick();
    RST_I = 1'b0;
    tick();

    // reset while in service clears everything
    bus_write(REG_STATUS, 32'h1);
    bus_write(REG_EDGE, 32'h00);
    bus_write(REG_MASK, 32'h10);
    HWINT_I[4] = 1'b1;
    tick(); tick(); tick();
    ack_pulse();
    check("t7_in_svc", 32'(o_dbg_state), 32'(ST_SERVICE));
    HWINT_I = '0;
    RST_I = 1'b1;
    #1;
    check("t7_rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("t7_rst_req", 32'(INT_REQ_O), 32'd0);
    for (int a = 0; a < 4; a++) read_check("t7_rst_reg", 2'(a), 32'd0);
    tick(); tick();
    RST_I = 1'b0;
    repeat (5) tick();
    check("t7_no_req", 32'(INT_REQ_O), 32'd0);

    // random traffic against the model
    bus_write(REG_STATUS, 32'h1);
    bus_write(REG_MASK, 32'h3F);
    bus_write(REG_EDGE, 32'(($urandom_range(0, 63))));
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) HWINT_I[i] = ~HWINT_I[i];
      INT_ACK_I = ($urandom_range(0, 3) == 0);
      ADD_I     = 2'($urandom_range(0, 3));
      WE_I      = ($urandom_range(0, 5) == 0);
      DAT_I     = $urandom;
      if (ADD_I == REG_STATUS) DAT_I[0] = ($urandom_range(0, 7) != 0);
      tick();
    end
    WE_I = 1'b0; INT_ACK_I = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
